// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: E-stage initiator for the multiply/divide unit.
// Ports: clk/reset(async, low); d_md_op, e_md_op, e_valid, flush, e_rs, e_rt
//   from the pipeline; md_busy/md_hi/md_lo from MD; md_start/md_sa/md_sb to MD;
//   stall_d to D stage; e_md_result (mfhi/mflo); err (sticky); issue_cnt.
module md_issue_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       d_md_op,
  input  logic [3:0]       e_md_op,
  input  logic             e_valid,
  input  logic             flush,
  input  logic [31:0]      e_rs,
  input  logic [31:0]      e_rt,
  input  logic             md_busy,
  input  logic [31:0]      md_hi,
  input  logic [31:0]      md_lo,
  output logic [3:0]       md_start,
  output logic [31:0]      md_sa,
  output logic [31:0]      md_sb,
  output logic             stall_d,
  output logic [31:0]      e_md_result,
  output logic             err,
  output logic [CNT_W-1:0] issue_cnt
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_n;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_n;
  logic       op_ok;
  logic       op_long;
  logic       op_bad;
  logic       issue;
  logic       long_op;
  logic       busy_wait;
  logic       fire;
  logic       err_n;

  assign op_ok   = (e_md_op != 4'd0) && (e_md_op <= 4'd8);
  assign op_long = (e_md_op != 4'd0) && (e_md_op <= 4'd4);
  assign op_bad  = e_md_op >= 4'd9;

  // reset gates issue so nothing reaches MD while held in reset
  assign issue   = e_valid & ~flush & op_ok & reset;
  assign long_op = issue & op_long;

  // MD raises busy one cycle late; long_op covers the issue cycle itself
  assign busy_wait = (state == S_WAIT) & md_busy;

  assign md_start = issue ? e_md_op : 4'd0;
  assign md_sa    = e_rs;
  assign md_sb    = e_rt;
  assign stall_d  = (d_md_op != 4'd0) & (long_op | busy_wait);

  always_comb begin
    e_md_result = 32'd0;
    unique case (1'b1)
      (e_md_op == 4'd5): e_md_result = md_hi;
      (e_md_op == 4'd6): e_md_result = md_lo;
      default: ;
    endcase
  end

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    fire       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (long_op) begin
          state_n    = S_WAIT;
          wait_cnt_n = 8'd0;
        end
      end
      S_WAIT: begin
        if (long_op) begin
          wait_cnt_n = 8'd0;
        end else if (!md_busy) begin
          state_n    = S_IDLE;
          wait_cnt_n = 8'd0;
        end else if (wait_cnt == TO_LAST) begin
          fire       = 1'b1;
          state_n    = S_IDLE;
          wait_cnt_n = 8'd0;
        end else begin
          wait_cnt_n = wait_cnt + 8'd1;
        end
      end
    endcase
  end

  // issuing into a busy MD means the pipeline failed to stall
  assign err_n = err | fire | (issue & busy_wait)
               | (e_valid & ~flush & op_bad);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wait_cnt  <= 8'd0;
      err       <= 1'b0;
      issue_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      err      <= err_n;
      if (issue) issue_cnt <= issue_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Pipeline-side initiator for the multiply/divide unit. Sits in the E stage between the decode/execute pipeline and the MD unit.
- Decodes the E-stage MD opcode and drives the MD start/operand interface.
- Tracks MD occupancy and raises the D-stage stall when an MD instruction must wait.
- Returns HI/LO for mfhi/mflo, and provides a watchdog, a protocol-error flag and an issue counter for verification.

Parameters:
TIMEOUT, 15, max consecutive cycles in WAIT before the watchdog fires (range 1..255)
CNT_W, 16, width of the issued-operation counter

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low (0 = reset)
d_md_op  input  4  MD opcode of the D-stage instruction (0 = none)
e_md_op  input  4  MD opcode of the E-stage instruction (0 = none)
e_valid  input  1  E-stage instruction valid (not a bubble)
flush  input  1  E-stage kill (exception/eret); suppresses issue this cycle
e_rs  input  32  E-stage rs operand
e_rt  input  32  E-stage rt operand
md_busy  input  1  MD unit busy
md_hi  input  32  MD HI register
md_lo  input  32  MD LO register
md_start  output  4  opcode strobe to MD (0 = idle)
md_sa  output  32  operand A to MD
md_sb  output  32  operand B to MD
stall_d  output  1  freeze D stage, insert bubble into E
e_md_result  output  32  mfhi/mflo result
err  output  1  sticky protocol/timeout error
issue_cnt  output  CNT_W  count of accepted issues

Behaviour:
- Opcodes:
  - 1 = mult, 2 = multu, 3 = div, 4 = divu (long ops)
  - 5 = mfhi, 6 = mflo (reads)
  - 7 = mthi, 8 = mtlo (writes)
  - 9..15 are illegal.
- issue = e_valid & !flush & (e_md_op in 1..8) & reset.
- long = issue & (e_md_op in 1..4).
- md_start = issue ? e_md_op : 0. Combinational; forced to 0 while reset is low.
- md_sa = e_rs and md_sb = e_rt, unconditional pass-through.
- e_md_result:
  - md_hi when e_md_op = 5
  - md_lo when e_md_op = 6
  - 0 otherwise.
  - No gating by e_valid.
- MD timing contract: the MD samples start at edge T, and md_busy first rises in the cycle after T. The controller covers that gap itself.
- FSM states are IDLE and WAIT. Reset state is IDLE.
  - IDLE -> WAIT on an edge where long = 1.
  - WAIT -> IDLE on an edge where md_busy = 0.
  - WAIT -> IDLE on the watchdog firing.
  - A long issue while in WAIT with md_busy = 0 is legal and keeps the FSM in WAIT. The wait counter reloads to 0.
- wait_cnt (8 bits):
  - Cleared on entry to WAIT.
  - Increments each WAIT cycle with md_busy = 1.
  - When it reaches TIMEOUT with md_busy still 1: set err, go to IDLE.
- stall_d = (d_md_op != 0) & (long | (state == WAIT & md_busy)).
  - Purely combinational, no registered delay.
  - stall_d = 0 whenever d_md_op = 0.
- err is sticky until reset. It sets on any of:
  - the watchdog firing;
  - issue while state == WAIT & md_busy (the pipeline failed to stall);
  - e_valid & !flush & e_md_op >= 9.
- issue_cnt increments by 1 on every edge with issue = 1, and wraps at 2^CNT_W.
- flush has priority over e_valid: no start, no count, no state change.
- Reset mid-WAIT: immediately IDLE, err = 0, issue_cnt = 0, md_start = 0, stall_d depends only on the live inputs.
- Reset values: state IDLE, wait_cnt 0, err 0, issue_cnt 0.

Test Plan:
- Release reset, then drive e_md_op = 1, e_valid = 1, e_rs = 7, e_rt = -3 for one cycle -> md_start = 1 that cycle, md_sa = 7, md_sb = 0xFFFFFFFD, issue_cnt = 1. With the MD model, after busy falls, e_md_op = 6 gives e_md_result = 0xFFFFFFEB.
- Issue div (3), hold d_md_op = 5 throughout -> stall_d = 1 in the issue cycle and in every md_busy = 1 cycle (10 cycles, 11 total). stall_d = 0 on the first cycle busy = 0.
- Issue mult with flush = 1 -> md_start = 0, state stays IDLE, issue_cnt unchanged, stall_d = 0 with d_md_op = 5.
- Tie md_busy = 1 after a long issue with TIMEOUT = 15 -> err rises after 15 WAIT cycles, FSM returns to IDLE, stall_d then drops.
- Issue mult, then force e_md_op = 2 while md_busy = 1 -> err = 1. Separately, e_md_op = 12 with e_valid = 1 -> err = 1, md_start = 0.
- Drive reset low mid-WAIT asynchronously, between clock edges -> err = 0, issue_cnt = 0, md_start = 0 at once. After release, d_md_op = 5 with no issue gives stall_d = 0.
